mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the pipeline's fetch (F) and load/store (M) stages.
//  - Serialises requests and counts a fixed memory latency.
//  - Returns read data per port.
//  - Drives per-port stall flags into the hazard unit; any stall freezes the pipeline.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/arb_lat_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and owner
// encodings, the latency bound and a helper that turns the latency
// parameter into the down-counter load value.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_ACC = 3'd1,
    DM_ACC = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  localparam int MEM_LAT_MAX = 8;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

  // Clamp the configured latency into 1..MEM_LAT_MAX so the counter can
  // never be loaded with 0 (which would leave WAIT without a hit).
  function automatic logic [LAT_CNT_W-1:0] lat_load_value(input int lat);
    int clamped;
    clamped = lat;
    if (clamped < 1) clamped = 1;
    if (clamped > MEM_LAT_MAX) clamped = MEM_LAT_MAX;
    return LAT_CNT_W'(clamped);
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times the memory read latency. hit is high
// while the count equals 1, i.e. in the cycle mem_rdata is valid.
module arb_lat_counter
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 hit
);

  logic [LAT_CNT_W-1:0] cnt;

  // Load takes precedence over decrement; the count stops at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - LAT_CNT_W'(1);
    end
  end

  assign hit = (cnt == LAT_CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch (IF)
// and load/store (DM) stages. Requests are serialised, a fixed memory
// latency is counted, read data is returned per port and per-port stall
// flags feed the hazard unit.
// Optional feature: define MEM_ARB_PERF_CNT_EN to build the saturating
// stall-cycle counters; otherwise perf_if_stall/perf_dm_stall read 0.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_stall
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load_value(MEM_LAT);

  arb_state_t        state;
  arb_owner_t        owner;
  logic              lat_we;
  logic [ADDR_W-3:0] lat_waddr;
  logic [DATA_W-1:0] lat_wdata;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_hit;

  // Byte-offset bits are intentionally dropped: the memory is word
  // addressed and misalignment is not reported.
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^{if_addr[1:0], dm_addr[1:0]};

  assign mem_addr  = lat_waddr;
  assign mem_wdata = lat_wdata;

  // A requester that has just received its pulse still holds req in that
  // cycle, so the stall flag must already be low there.
  assign stall_if = if_req & ~if_valid;
  assign stall_dm = dm_req & ~dm_done;

  // Start timing only for reads; stores complete without waiting.
  assign cnt_load = ((state == IF_ACC) || (state == DM_ACC)) && !lat_we;
  assign cnt_dec  = (state == WAIT);

  arb_lat_counter u_lat_counter (
    .clk      (clka),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .hit      (cnt_hit)
  );

  // Capture the winner's address and store data while arbitrating; held
  // stable for the whole transaction so the memory sees a steady address.
  always_ff @(posedge clka) begin
    if (state == IDLE) begin
      if (dm_req) begin
        lat_waddr <= dm_addr[ADDR_W-1:2];
        lat_wdata <= dm_wdata;
      end else if (if_req) begin
        lat_waddr <= if_addr[ADDR_W-1:2];
      end
    end
  end

  // Arbitration FSM with registered strobes, pulses and read-data registers.
  always_ff @(posedge clka) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      lat_we   <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      dm_done  <= 1'b0;
      case (state)
        IDLE: begin
          // The data access belongs to the older instruction, so it wins.
          if (dm_req) begin
            owner  <= OWN_DM;
            lat_we <= dm_we;
            mem_en <= 1'b1;
            mem_we <= dm_we;
            state  <= DM_ACC;
          end else if (if_req) begin
            owner  <= OWN_IF;
            lat_we <= 1'b0;
            mem_en <= 1'b1;
            state  <= IF_ACC;
          end
        end
        IF_ACC, DM_ACC: begin
          if (lat_we) begin
            dm_done <= (owner == OWN_DM);
            state   <= RESP;
          end else begin
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_hit) begin
            if (owner == OWN_DM) begin
              dm_rdata <= mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
            dm_done  <= (owner == OWN_DM);
            if_valid <= (owner == OWN_IF);
            state    <= RESP;
          end
        end
        RESP: begin
          // No arbitration here: the owner still holds its finished request.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_q;
  logic [31:0] perf_dm_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count stall cycles per port, saturating at all-ones.
  always_ff @(posedge clka) begin
    if (!rst) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
    end else begin
      if (stall_if) perf_if_q <= sat_inc(perf_if_q);
      if (stall_dm) perf_dm_q <= sat_inc(perf_dm_q);
    end
  end

  assign perf_if_stall = perf_if_q;
  assign perf_dm_stall = perf_dm_q;
`else
  assign perf_if_stall = '0;
  assign perf_dm_stall = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: two instances (MEM_LAT=1 and
// MEM_LAT=4), each with a small behavioural memory. Expected responses
// go to per-port scoreboard queues and are popped when a pulse appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic [31:0] if_rdata  [2];
  logic        if_valid  [2];
  logic        dm_req    [2];
  logic        dm_we     [2];
  logic [31:0] dm_addr   [2];
  logic [31:0] dm_wdata  [2];
  logic [31:0] dm_rdata  [2];
  logic        dm_done   [2];
  logic        stall_if  [2];
  logic        stall_dm  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [29:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] perf_if   [2];
  logic [31:0] perf_dm   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 4;
    logic [31:0] mem_g [128];
    logic [31:0] pipe  [8];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
      .clka(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_valid(if_valid[g]),
      .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_rdata(dm_rdata[g]), .dm_done(dm_done[g]),
      .stall_if(stall_if[g]), .stall_dm(stall_dm[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .perf_if_stall(perf_if[g]), .perf_dm_stall(perf_dm[g])
    );

    // Memory model: word i holds 0x2008_0001+i after reset; read data is
    // valid exactly L cycles after the mem_en cycle and garbage otherwise.
    always @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < 128; i++) mem_g[i] <= 32'h2008_0001 + i;
        for (int k = 0; k < 8; k++) pipe[k] <= 32'h0BAD_0BAD;
      end else begin
        if (mem_en[g] && mem_we[g]) mem_g[mem_addr[g][6:0]] <= mem_wdata[g];
        pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem_g[mem_addr[g][6:0]] : 32'h0BAD_0BAD;
        for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign mem_rdata[g] = pipe[L-1];
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          inst;
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          lat;
  } vec_t;

  exp_t        q0[$], q1[$], q2[$], q3[$];
  logic [31:0] sh_if [2];
  logic [31:0] sh_dm [2];
  vec_t        vecs  [9];

`ifdef MEM_ARB_PERF_CNT_EN
  localparam logic [31:0] EXP_PERF_IF0 = 32'd7;
  localparam logic [31:0] EXP_PERF_DM0 = 32'd3;
  localparam logic [31:0] EXP_PERF_IF1 = 32'd6;
`else
  localparam logic [31:0] EXP_PERF_IF0 = 32'd0;
  localparam logic [31:0] EXP_PERF_DM0 = 32'd0;
  localparam logic [31:0] EXP_PERF_IF1 = 32'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] data, input int c);
    exp_t e;
    e.data = data;
    e.cyc  = c;
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic flush_sb();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int g = 0; g < 2; g++) begin
      sh_if[g] = '0;
      sh_dm[g] = '0;
    end
  endtask

  task automatic pop_check(input int g, input bit dm, input logic [31:0] act);
    exp_t e;
    bit   have;
    have = 1'b0;
    e.data = '0;
    e.cyc  = 0;
    case (g * 2 + int'(dm))
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
    endcase
    chk($sformatf("pulse_expected%0d_%s", g, dm ? "dm" : "if"), {31'd0, have}, 32'd1);
    if (have) begin
      chk($sformatf("rdata%0d_%s", g, dm ? "dm" : "if"), act, e.data);
      chk($sformatf("latency%0d_%s", g, dm ? "dm" : "if"), cyc, e.cyc);
      if (dm) sh_dm[g] = e.data;
      else    sh_if[g] = e.data;
    end
  endtask

  // Called at the falling edge of every cycle.
  task automatic monitor();
    for (int g = 0; g < 2; g++) begin
      if (if_valid[g]) pop_check(g, 1'b0, if_rdata[g]);
      if (dm_done[g]) begin
        pop_check(g, 1'b1, dm_rdata[g]);
        chk($sformatf("if_rdata_hold%0d", g), if_rdata[g], sh_if[g]);
      end
      if (mem_we[g] && !mem_en[g]) chk($sformatf("we_without_en%0d", g), 32'd1, 32'd0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on one port; caller starts with the DUT idle.
  task automatic run_req(input int g, input bit dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] data, input int lat);
    bit   seen;
    logic stl;
    int   c0;
    c0 = cyc;
    if (dm) begin
      dm_req[g] = 1'b1; dm_we[g] = we; dm_addr[g] = addr; dm_wdata[g] = wdata;
      push_exp(g * 2 + 1, we ? sh_dm[g] : data, c0 + lat);
    end else begin
      if_req[g] = 1'b1; if_addr[g] = addr;
      push_exp(g * 2, data, c0 + lat);
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      stl = dm ? stall_dm[g] : stall_if[g];
      chk($sformatf("stall%0d_k%0d", g, k), {31'd0, stl}, {31'd0, (k < lat)});
      chk($sformatf("mem_en%0d_k%0d", g, k), {31'd0, mem_en[g]}, {31'd0, (k == 1)});
      if (k == 1) begin
        chk($sformatf("mem_we%0d", g), {31'd0, mem_we[g]}, {31'd0, we});
        chk($sformatf("mem_addr%0d", g), {2'b00, mem_addr[g]}, {2'b00, addr[31:2]});
        if (we) chk($sformatf("mem_wdata%0d", g), mem_wdata[g], wdata);
      end
      seen = dm ? dm_done[g] : if_valid[g];
      monitor();
      advance();
    end
    chk($sformatf("done_seen%0d", g), {31'd0, seen}, 32'd1);
    if (dm) dm_req[g] = 1'b0;
    else    if_req[g] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=hang required=finish", cyc);
    $fatal(1);
  end

  initial begin
    bit d, v;
    int c0;

    vecs[0] = '{0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'h2008_0005, 3};
    vecs[1] = '{0, 1'b1, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF,  32'h0,         2};
    vecs[2] = '{0, 1'b1, 1'b0, 32'h0000_0044, 32'h0,          32'hDEAD_BEEF, 3};
    vecs[3] = '{0, 1'b0, 1'b0, 32'h0000_0047, 32'h0,          32'hDEAD_BEEF, 3};
    vecs[4] = '{0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h2008_0001, 3};
    vecs[5] = '{1, 1'b1, 1'b0, 32'h0000_0100, 32'h0,          32'h2008_0041, 6};
    vecs[6] = '{1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,          32'h2008_0003, 6};
    vecs[7] = '{1, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678,  32'h0,         2};
    vecs[8] = '{1, 1'b0, 1'b0, 32'h0000_000A, 32'h0,          32'h1234_5678, 6};

    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      if_req[g] = 1'b0; if_addr[g] = '0;
      dm_req[g] = 1'b0; dm_we[g] = 1'b0; dm_addr[g] = '0; dm_wdata[g] = '0;
    end
    flush_sb();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_if_rdata%0d", g), if_rdata[g], 32'h0);
      chk($sformatf("rst_dm_rdata%0d", g), dm_rdata[g], 32'h0);
      chk($sformatf("rst_if_valid%0d", g), {31'd0, if_valid[g]}, 32'd0);
      chk($sformatf("rst_dm_done%0d", g), {31'd0, dm_done[g]}, 32'd0);
      chk($sformatf("rst_mem_en%0d", g), {31'd0, mem_en[g]}, 32'd0);
      chk($sformatf("rst_perf_if%0d", g), perf_if[g], 32'h0);
      chk($sformatf("rst_perf_dm%0d", g), perf_dm[g], 32'h0);
    end
    monitor();
    advance();

    // Table-driven single transactions
    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].inst, vecs[i].dm, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, vecs[i].data, vecs[i].lat);
    end

    // Fetch request dropped mid-transaction still completes
    c0 = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_0010;
    push_exp(0, 32'h2008_0005, c0 + 3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      monitor();
      advance();
      if_req[0] = 1'b0;
    end
    chk("drop_mid_if_rdata", if_rdata[0], 32'h2008_0005);

    // Reset during a MEM_LAT=4 fetch discards the response
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      monitor();
      advance();
    end
    rst = 1'b0;
    @(negedge clk);
    monitor();
    advance();
    rst = 1'b1;
    if_req[1] = 1'b0;
    flush_sb();
    @(negedge clk);
    chk("midrst_if_rdata1", if_rdata[1], 32'h0);
    chk("midrst_dm_rdata1", dm_rdata[1], 32'h0);
    chk("midrst_mem_en1", {31'd0, mem_en[1]}, 32'd0);
    chk("midrst_if_valid1", {31'd0, if_valid[1]}, 32'd0);
    chk("midrst_if_rdata0", if_rdata[0], 32'h0);
    monitor();
    advance();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      monitor();
      advance();
    end
    run_req(1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h2008_0005, 6);

    // Simultaneous requests: DM first, then IF
    c0 = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_0010;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h0000_0000;
    push_exp(1, 32'h2008_0001, c0 + 3);
    push_exp(0, 32'h2008_0005, c0 + 7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("both_stall_if_k%0d", k), {31'd0, stall_if[0]}, {31'd0, (k < 7)});
      chk($sformatf("both_stall_dm_k%0d", k), {31'd0, stall_dm[0]}, {31'd0, (k < 3)});
      d = dm_done[0];
      v = if_valid[0];
      monitor();
      advance();
      if (d) dm_req[0] = 1'b0;
      if (v) if_req[0] = 1'b0;
    end
    chk("sb_empty_if0", q0.size(), 32'd0);
    chk("sb_empty_dm0", q1.size(), 32'd0);
    chk("perf_if0", perf_if[0], EXP_PERF_IF0);
    chk("perf_dm0", perf_dm[0], EXP_PERF_DM0);
    chk("perf_if1", perf_if[1], EXP_PERF_IF1);
    chk("perf_dm1", perf_dm[1], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
